// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS
// transfers and reports completion (or timeout abort) on a response strobe.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    // Wait-state counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ADDR_W-1:0] paddr_next;
    logic              pwrite_next;
    logic [DATA_W-1:0] pwdata_next;
    logic              psel_next;
    logic              penable_next;
    logic              rsp_valid_next;
    logic              rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_next;

    // Register the state and every APB/response output; reset clears all of it,
    // including a transfer that is mid-flight, without emitting a response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            PADDR     <= paddr_next;
            PWRITE    <= pwrite_next;
            PWDATA    <= pwdata_next;
            PSELx     <= psel_next;
            PENABLE   <= penable_next;
            rsp_valid <= rsp_valid_next;
            rsp_err   <= rsp_err_next;
            rsp_rdata <= rsp_rdata_next;
        end
    end

    // Next-state and next-output logic; a completing ACCESS may accept the next
    // command directly so back-to-back transfers skip IDLE.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        paddr_next     = PADDR;
        pwrite_next    = PWRITE;
        pwdata_next    = PWDATA;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = rsp_rdata;
        cmd_ready      = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    paddr_next  = cmd_addr;
                    pwrite_next = cmd_write;
                    pwdata_next = cmd_wdata;
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                cmd_ready = PREADY;
                if (PREADY) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = PWRITE ? '0 : PRDATA;
                    if (cmd_valid) begin
                        paddr_next  = cmd_addr;
                        pwrite_next = cmd_write;
                        pwdata_next = cmd_wdata;
                        state_next  = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_rdata_next = '0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        psel_next    = (state_next != IDLE);
        penable_next = (state_next == ACCESS);
    end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a transaction-level completer model plus an
// expected-response queue checked by an independent monitor.
module tb_apb_master;

    localparam int T = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Count rising edges so response latency can be checked in cycles.
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        $display("[TB] FAIL %s", name);
    endtask

    // Drive one command, wait (bounded) for acceptance, then record what the
    // completer should do and what response must come back and when.
    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int waits, input int gap);
        bit    acc = 0;
        int    budget = 0;
        plan_t p;
        exp_t  e;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!acc && budget < 100) begin
            #2;
            acc = cmd_ready;
            if (acc) begin
                p.wr = wr; p.addr = addr; p.wdata = wdata; p.rdata = rdata; p.waits = waits;
                plan_q.push_back(p);
                e.err   = (waits >= T);
                e.rdata = (!wr && waits < T) ? rdata : 32'h0;
                e.cyc   = cyc + 3 + ((waits >= T) ? T - 1 : waits);
                exp_q.push_back(e);
                @(posedge PCLK);
            end else begin
                @(negedge PCLK);
                budget++;
            end
        end
        if (!acc) report_fail("cmd_accept_timeout");
        #1;
        cmd_valid = 1'b0;
        repeat (gap) @(posedge PCLK);
    endtask

    // Wait (bounded) until every issued command has been responded to.
    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && b < 200) begin
            @(negedge PCLK);
            b++;
        end
        if (exp_q.size() != 0 || plan_q.size() != 0) report_fail("drain_timeout");
        repeat (2) @(negedge PCLK);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_psel", PSELx, 0);
        check_output("rst_penable", PENABLE, 0);
        check_output("rst_pwrite", PWRITE, 0);
        check_output("rst_paddr", PADDR, 0);
        check_output("rst_pwdata", PWDATA, 0);
        check_output("rst_rsp_valid", rsp_valid, 0);
        check_output("rst_rsp_rdata", rsp_rdata, 0);
        check_output("rst_rsp_err", rsp_err, 0);
        check_output("rst_cmd_ready", cmd_ready, 1);
    endtask

    // Completer model: picks up each transfer at SETUP, checks the APB bus is
    // stable through ACCESS, and raises PREADY after the planned wait states.
    plan_t cur;
    bit    active = 0;
    int    wcnt = 0;
    always @(negedge PCLK) begin
        if (PRESET) begin
            active = 0;
            PREADY = 1'b0;
        end else if (PSELx && !PENABLE) begin
            PREADY = 1'b0;
            if (plan_q.size() == 0) begin
                report_fail("unexpected_setup");
                active = 0;
            end else begin
                cur = plan_q.pop_front();
                active = 1;
                wcnt = 0;
                check_output("setup_paddr", PADDR, cur.addr);
                check_output("setup_pwrite", PWRITE, cur.wr);
                if (cur.wr) check_output("setup_pwdata", PWDATA, cur.wdata);
            end
        end else if (PSELx && PENABLE && active) begin
            check_output("access_paddr", PADDR, cur.addr);
            check_output("access_pwrite", PWRITE, cur.wr);
            if (cur.wr) check_output("access_pwdata", PWDATA, cur.wdata);
            PREADY = (wcnt >= cur.waits);
            PRDATA = cur.wr ? $urandom : cur.rdata;
            wcnt++;
        end else begin
            PREADY = 1'b0;
            PRDATA = $urandom;
        end
    end

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET && rsp_valid) begin
            if (exp_q.size() == 0) begin
                report_fail("unexpected_rsp");
            end else begin
                e = exp_q.pop_front();
                check_output("rsp_rdata", rsp_rdata, e.rdata);
                check_output("rsp_err", rsp_err, e.err);
                check_output("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Directed corner cases, a randomized run, then reset during ACCESS.
    initial begin
        int b;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_reset_outputs();
        PRESET = 1'b0;
        @(negedge PCLK);
        check_output("idle_cmd_ready", cmd_ready, 1);

        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        apply_stimulus(1'b0, 32'h20, 32'h0, 32'h12345678, 0, 2);
        apply_stimulus(1'b0, 32'h24, 32'h0, 32'hCAFEF00D, 3, 2);
        apply_stimulus(1'b0, 32'h28, 32'h0, 32'hAAAA5555, T, 2);
        apply_stimulus(1'b0, 32'h2C, 32'h0, 32'h0BADF00D, T - 1, 2);
        apply_stimulus(1'b1, 32'h2E, 32'h77778888, 32'h0, T + 1, 2);
        apply_stimulus(1'b1, 32'h30, 32'h11112222, 32'h0, 0, 0);
        apply_stimulus(1'b0, 32'h34, 32'h0, 32'h33334444, 0, 2);
        drain();

        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                           $urandom_range(0, T + 1), $urandom_range(0, 2));
        end
        drain();

        apply_stimulus(1'b0, 32'h40, 32'h0, 32'h5A5A5A5A, 3, 0);
        b = 0;
        while (!PENABLE && b < 20) begin
            @(negedge PCLK);
            b++;
        end
        if (!PENABLE) report_fail("access_not_reached");
        PRESET = 1'b1;
        exp_q.delete();
        plan_q.delete();
        @(posedge PCLK);
        @(negedge PCLK);
        check_reset_outputs();
        PRESET = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            check_output("post_rst_rsp_valid", rsp_valid, 0);
        end

        apply_stimulus(1'b0, 32'h44, 32'h0, 32'h13572468, 1, 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case something wedges the stimulus thread.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        n_checks++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
